alu_arbiter: RTL and testbench

Sequences and shares one combinational alu instance between two requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, captures the result and flags, and returns them on a single tagged response channel. It sits between the instruction-issue logic and the alu datapath.

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle with registered ALU inputs,
// then a tagged response held in RESP until the consumer accepts it.
// Optional build macro: ALU_STICKY_FLAGS_EN adds an accumulated flag
// register (sticky_flags) cleared by sticky_clr.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; grants the round-robin winner
// EXEC  | ALU driven from registered operands; result captured on edge
// RESP  | response presented; leaves on rsp_valid & rsp_ready
module alu_arbiter #(
   parameter int BW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [BW-1:0] req0_a,
   input  logic [BW-1:0] req0_b,
   input  logic [3:0]    req0_op,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [BW-1:0] req1_a,
   input  logic [BW-1:0] req1_b,
   input  logic [3:0]    req1_op,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [BW-1:0] rsp_out,
   output logic [2:0]    rsp_flags,
   output logic [BW-1:0] alu_a,
   output logic [BW-1:0] alu_b,
   output logic [3:0]    alu_opcode,
   input  logic [BW-1:0] alu_out,
   input  logic [2:0]    alu_flags,
   output logic [2:0]    sticky_flags,
   input  logic          sticky_clr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] OP_NOP = 4'b1111;

   state_t        state_q, state_d;
   logic [BW-1:0] alu_a_q, alu_a_d;
   logic [BW-1:0] alu_b_q, alu_b_d;
   logic [3:0]    alu_op_q, alu_op_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_id_q, rsp_id_d;
   logic [BW-1:0] rsp_out_q, rsp_out_d;
   logic [2:0]    rsp_flags_q, rsp_flags_d;
   logic          last_grant_q, last_grant_d;
   logic          win1;

   // Requester 1 wins when it is alone or when requester 0 held the last grant.
   assign win1 = req1_valid & (~req0_valid | ~last_grant_q);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= OP_NOP;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_out_q    <= '0;
         rsp_flags_q  <= 3'b000;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_out_q    <= rsp_out_d;
         rsp_flags_q  <= rsp_flags_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state, grant and capture logic.
   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_out_d    = rsp_out_q;
      rsp_flags_d  = rsp_flags_q;
      last_grant_d = last_grant_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               req0_ready   = ~win1;
               req1_ready   = win1;
               alu_a_d      = win1 ? req1_a  : req0_a;
               alu_b_d      = win1 ? req1_b  : req0_b;
               alu_op_d     = win1 ? req1_op : req0_op;
               rsp_id_d     = win1;
               last_grant_d = win1;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_out_d   = alu_out;
            rsp_flags_d = alu_flags;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_out    = rsp_out_q;
   assign rsp_flags  = rsp_flags_q;

`ifdef ALU_STICKY_FLAGS_EN
   logic [2:0] sticky_q;

   // Accumulate flags on each capture; a clear in the same cycle keeps only the new flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 3'b000;
      end else if (sticky_clr && state_q == EXEC) begin
         sticky_q <= alu_flags;
      end else if (sticky_clr) begin
         sticky_q <= 3'b000;
      end else if (state_q == EXEC) begin
         sticky_q <= sticky_q | alu_flags;
      end
   end

   assign sticky_flags = sticky_q;
`else
   logic unused_sticky_clr;

   assign unused_sticky_clr = sticky_clr;
   assign sticky_flags      = 3'b000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (grant order, response payload, timing).
module tb_alu_arbiter;

   localparam int BW = 16;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
`ifdef ALU_STICKY_FLAGS_EN
   localparam logic [2:0] STICKY_EXP = 3'b111;
`else
   localparam logic [2:0] STICKY_EXP = 3'b000;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [BW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]    req0_op, req1_op;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [BW-1:0] rsp_out;
   logic [2:0]    rsp_flags;
   logic [BW-1:0] alu_a, alu_b, alu_out;
   logic [3:0]    alu_opcode;
   logic [2:0]    alu_flags;
   logic [2:0]    sticky_flags;
   logic          sticky_clr;

   int n_vec = 0;
   int n_err = 0;

   // model state: 0 idle, 1 op in flight, 2 response pending
   int            m_phase;
   logic          m_last;
   logic          pend_id;
   logic [BW-1:0] pend_out;
   logic [2:0]    pend_flags;
   logic [2:0]    m_sticky;
   logic          g0, g1;
   logic          ids_seen[$];

   alu_arbiter #(.BW(BW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out(rsp_out), .rsp_flags(rsp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {overflow, negative, zero, result}.
   function automatic logic [BW+2:0] alu_fn(logic [3:0] op, logic [BW-1:0] a, logic [BW-1:0] b);
      logic [BW-1:0] r;
      logic          ov;
      ov = 1'b0;
      case (op)
         4'd0: begin r = a + b; ov = (a[BW-1] == b[BW-1]) && (r[BW-1] != a[BW-1]); end
         4'd1: begin r = a - b; ov = (a[BW-1] != b[BW-1]) && (r[BW-1] != a[BW-1]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         default: r = '0;
      endcase
      return {ov, r[BW-1], (r == '0), r};
   endfunction

   always_comb {alu_flags, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_last   = 1'b1;
      m_sticky = 3'b000;
      g0       = 1'b0;
      g1       = 1'b0;
   endtask

   task automatic check_reset_vals();
      chk("rst_alu_a", 32'(alu_a), 32'h0);
      chk("rst_alu_b", 32'(alu_b), 32'h0);
      chk("rst_alu_op", 32'(alu_opcode), 32'hF);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_rsp_out", 32'(rsp_out), 32'h0);
      chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
      chk("rst_sticky", 32'(sticky_flags), 32'h0);
   endtask

   // Async reset pulse from the middle of a cycle; requesters withdraw meanwhile.
   task automatic apply_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One clock: compare at the falling edge against the model, then advance it.
   task automatic cycle();
      logic          e0, e1;
      logic [BW+2:0] res;
      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
      if (m_phase == 0) begin
         e1 = req1_valid && (!req0_valid || m_last == 1'b0);
         e0 = req0_valid && !e1;
      end
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
         chk("rsp_id", 32'(rsp_id), 32'(pend_id));
         chk("rsp_out", 32'(rsp_out), 32'(pend_out));
         chk("rsp_flags", 32'(rsp_flags), 32'(pend_flags));
         if (rsp_ready) ids_seen.push_back(rsp_id);
      end
      chk("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
`ifdef ALU_STICKY_FLAGS_EN
      if (m_phase == 1 && sticky_clr) m_sticky = pend_flags;
      else if (sticky_clr)            m_sticky = 3'b000;
      else if (m_phase == 1)          m_sticky = m_sticky | pend_flags;
`endif
      case (m_phase)
         0: if (e0 || e1) begin
               res = e1 ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
               pend_id    = e1;
               pend_out   = res[BW-1:0];
               pend_flags = res[BW+2:BW];
               m_last     = e1;
               m_phase    = 1;
            end
         1: m_phase = 2;
         default: if (rsp_ready) m_phase = 0;
      endcase
      g0 = e0;
      g1 = e1;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_drive();
      if (g0 || !req0_valid) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req0_a     = BW'($urandom);
         req0_b     = BW'($urandom);
         req0_op    = 4'($urandom_range(0, 15));
      end
      if (g1 || !req1_valid) begin
         req1_valid = ($urandom_range(0, 3) != 0);
         req1_a     = BW'($urandom);
         req1_b     = BW'($urandom);
         req1_op    = 4'($urandom_range(0, 15));
      end
      rsp_ready  = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      rsp_ready = 1'b1;
      sticky_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single op: 0x7FFF + 1 overflows into negative
      req0_valid = 1'b1; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_op = OP_ADD;
      rsp_ready = 1'b0;
      cycle();
      chk("single_grant", 32'(g0), 32'h1);
      req0_valid = 1'b0;
      cycle();
      chk("single_valid", 32'(rsp_valid), 32'h1);
      chk("single_id", 32'(rsp_id), 32'h0);
      chk("single_out", 32'(rsp_out), 32'h8000);
      chk("single_flags", 32'(rsp_flags), 32'h6);
      rsp_ready = 1'b1;
      repeat (2) cycle();

      // contention: both valid throughout, strict alternation from requester 0
      apply_reset();
      ids_seen.delete();
      req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; req0_op = OP_ADD;
      req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0005; req1_op = OP_SUB;
      rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (rsp_valid && rsp_id) begin
            chk("sub_out", 32'(rsp_out), 32'h0);
            chk("sub_flags", 32'(rsp_flags), 32'h1);
         end
      end
      chk("contend_count", 32'(ids_seen.size()), 32'd4);
      for (int i = 0; i < 4 && i < ids_seen.size(); i++)
         chk("contend_id", 32'(ids_seen[i]), 32'(i % 2));

      // backpressure: response held 5 cycles while requester 1 waits
      apply_reset();
      req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0F0F; req0_op = OP_AND;
      rsp_ready = 1'b0;
      cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0003; req1_op = OP_ADD;
      repeat (6) cycle();
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_out", 32'(rsp_out), 32'h0204);
      rsp_ready = 1'b1;
      cycle();
      chk("bp_no_early_grant", 32'(g1), 32'h0);
      cycle();
      chk("bp_grant_after", 32'(g1), 32'h1);
      req1_valid = 1'b0;
      repeat (3) cycle();

      // reset while an op is executing: nothing emitted, requester 0 first again
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h0001; req0_b = 16'h0001;
      req1_valid = 1'b1;
      begin : reach_exec
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            if (m_phase == 1) hit = 1'b1;
         end
         chk("exec_reached", 32'(hit), 32'h1);
      end
      apply_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      cycle();
      chk("rst_exec_first", 32'(g0), 32'h1);
      chk("rst_exec_no_rsp", 32'(rsp_valid), 32'h0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) cycle();

      // sticky accumulation then clear
      apply_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_op = OP_ADD;
      cycle();
      req0_valid = 1'b0;
      repeat (3) cycle();
      req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0000; req0_op = OP_AND;
      cycle();
      req0_valid = 1'b0;
      repeat (3) cycle();
      chk("sticky_acc", 32'(sticky_flags), 32'(STICKY_EXP));
      sticky_clr = 1'b1;
      cycle();
      sticky_clr = 1'b0;
      chk("sticky_clr", 32'(sticky_flags), 32'h0);
      cycle();

      // randomized traffic with occasional mid-stream reset
      for (int i = 0; i < 3000; i++) begin
         rand_drive();
         cycle();
         if ($urandom_range(0, 499) == 0) apply_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
